// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
//   WORD_W  : data word width (32)
//   state_t : responder FSM states IDLE / WAITING / RESP
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a CPU load/store unit and dmem_responder.
//   Req, We, Addr, Wdata : request fields, driven by the requester
//   Ready                : responder can accept a request this cycle
//   Rvalid, Rdata, Err   : one-cycle response, driven by the responder
// modport master : requester side
// modport slave  : responder side
interface dmem_if;
  import dmem_pkg::*;

  logic              Req;
  logic              We;
  logic [WORD_W-1:0] Addr;
  logic [WORD_W-1:0] Wdata;
  logic              Ready;
  logic              Rvalid;
  logic [WORD_W-1:0] Rdata;
  logic              Err;

  modport master (
    output Req, We, Addr, Wdata,
    input  Ready, Rvalid, Rdata, Err
  );

  modport slave (
    input  Req, We, Addr, Wdata,
    output Ready, Rvalid, Rdata, Err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x WORD_W word storage: synchronous write, combinational read.
// Contents are never reset.
//   Clk     : write clock
//   wr_en   : commit wr_data to word idx on the rising edge
//   idx     : word index shared by read and write
//   wr_data : data to store
//   rd_data : current contents of word idx
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) mem[idx] <= wr_data;
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT
// wait states, then returns a single-cycle Rvalid response.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : dmem_if.slave (Req/We/Addr/Wdata in, Ready/Rvalid/Rdata/Err out)
// Parameters: DEPTH (words, power of two >= 4), WAIT (0..15 wait states).
// Optional feature macro DMEM_ALIGN_CHK_EN: misaligned requests
// (Addr[1:0] != 0) skip the array and answer with Err=1, Rdata=0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic   Clk,
  input  logic   Reset,
  dmem_if.slave  bus
);

  localparam int       AW        = $clog2(DEPTH);
  localparam bit       NO_WAIT   = (WAIT == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Request fields captured on acceptance, needed while WAITING.
  logic              we_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              mis_q;

  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic              mis_in;
  logic              acc;
  logic              enter_resp;
  logic              we_e;
  logic [AW-1:0]     idx_e;
  logic [WORD_W-1:0] wdata_e;
  logic              mis_e;
  logic              wr_en;
  logic [WORD_W-1:0] rd_data;

`ifdef DMEM_ALIGN_CHK_EN
  assign mis_in = (bus.Addr[1:0] != 2'b00);
  logic unused_addr;
  assign unused_addr = ^bus.Addr[WORD_W-1:AW+2];
`else
  assign mis_in = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.Addr[WORD_W-1:AW+2], bus.Addr[1:0]};
`endif

  assign acc = (state == IDLE) && bus.Req;

  // With WAIT=0 the edge entering RESP is the acceptance edge itself, so the
  // array access must use the live bus fields rather than the captured copy.
  always_comb begin
    if (state == IDLE) begin
      we_e    = bus.We;
      idx_e   = bus.Addr[AW+1:2];
      wdata_e = bus.Wdata;
      mis_e   = mis_in;
    end else begin
      we_e    = we_q;
      idx_e   = idx_q;
      wdata_e = wdata_q;
      mis_e   = mis_q;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.Req) begin
          if (NO_WAIT) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAITING;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAITING: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  // Reset gates the write so an edge during reset can never commit a store.
  assign wr_en      = enter_resp && we_e && !mis_e && Reset;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (acc) begin
        we_q    <= bus.We;
        idx_q   <= bus.Addr[AW+1:2];
        wdata_q <= bus.Wdata;
        mis_q   <= mis_in;
      end
      if (enter_resp) begin
        rdata_q <= (we_e || mis_e) ? '0 : rd_data;
        err_q   <= mis_e;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .Clk     (Clk),
    .wr_en   (wr_en),
    .idx     (idx_e),
    .wr_data (wdata_e),
    .rd_data (rd_data)
  );

  assign bus.Ready  = (state == IDLE);
  assign bus.Rvalid = (state == RESP);
  assign bus.Rdata  = (state == RESP) ? rdata_q : '0;
  assign bus.Err    = (state == RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic Clk;
  logic Reset;

  int n_checks = 0;
  int n_errors = 0;

  dmem_if ia ();
  dmem_if ib ();

  dmem_responder #(.DEPTH(64), .WAIT(2)) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ia.slave)
  );

  dmem_responder #(.DEPTH(64), .WAIT(0)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ib.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      ia.Req = req; ia.We = we; ia.Addr = addr; ia.Wdata = wdata;
    end else begin
      ib.Req = req; ib.We = we; ib.Addr = addr; ib.Wdata = wdata;
    end
  endtask

  task automatic drop_req(input int sel);
    if (sel == 0) ia.Req = 1'b0;
    else          ib.Req = 1'b0;
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ia.Ready : ib.Ready;
  endfunction

  function automatic logic get_rvalid(input int sel);
    return (sel == 0) ? ia.Rvalid : ib.Rvalid;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? ia.Rdata : ib.Rdata;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? ia.Err : ib.Err;
  endfunction

  // One transaction; lat counts samples (#1 after each edge) from the
  // acceptance edge, the first sample being 1. lat = -1 on timeout.
  task automatic do_xfer(input int sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    int waited;
    @(negedge Clk);
    set_req(sel, 1'b1, we, addr, wdata);
    waited = 0;
    while (!get_ready(sel) && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    lat   = -1;
    rdata = 32'hBAD0_BAD0;
    err   = 1'bx;
    if (waited >= 20) begin
      drop_req(sel);
      return;
    end
    @(posedge Clk);
    #1;
    drop_req(sel);
    for (int n = 1; n <= 20; n++) begin
      if (get_rvalid(sel)) begin
        lat   = n;
        rdata = get_rdata(sel);
        err   = get_err(sel);
        break;
      end
      @(posedge Clk);
      #1;
    end
  endtask

  // Req held high for a number of cycles, starting from IDLE.
  task automatic held_req(input int sel, input int cycles, input int gap,
                          input int exp_acc, input int exp_low);
    int k, n_acc, last, gap_bad, n_rv, n_low;
    @(negedge Clk);
    k = 0;
    while (!get_ready(sel) && k < 20) begin
      @(negedge Clk);
      k++;
    end
    set_req(sel, 1'b1, 1'b0, 32'h10, 32'h0);
    n_acc = 0; last = -1; gap_bad = 0; n_rv = 0; n_low = 0;
    for (int c = 0; c < cycles; c++) begin
      if (c > 0) @(negedge Clk);
      if (get_ready(sel)) begin
        if (last >= 0 && (c - last) != gap) gap_bad++;
        last = c;
        n_acc++;
      end else begin
        n_low++;
      end
      if (get_rvalid(sel)) n_rv++;
    end
    drop_req(sel);
    chk("held_acceptances", 32'(n_acc), 32'(exp_acc));
    chk("held_spacing_bad", 32'(gap_bad), 32'd0);
    chk("held_rvalid_count", 32'(n_rv), 32'(exp_acc));
    chk("held_ready_low", 32'(n_low), 32'(exp_low));
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          rv_seen;

  initial begin
    Reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_ready", 32'(ia.Ready), 32'd1);
    chk("rst_rvalid", 32'(ia.Rvalid), 32'd0);
    chk("rst_rdata", ia.Rdata, 32'h0);
    chk("rst_err", 32'(ia.Err), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    // Store then load the same word
    do_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st10_lat", 32'(lat), 32'd3);
    chk("st10_rdata", rd, 32'h0);
    chk("st10_err", 32'(er), 32'd0);
    do_xfer(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld10_lat", 32'(lat), 32'd3);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err", 32'(er), 32'd0);

    // Address wrap modulo DEPTH*4 = 0x100
    do_xfer(0, 1'b1, 32'h04, 32'h12345678, rd, er, lat);
    chk("st04_lat", 32'(lat), 32'd3);
    do_xfer(0, 1'b0, 32'h104, 32'h0, rd, er, lat);
    chk("ld104_rdata", rd, 32'h12345678);

    // Outputs quiet outside the response cycle
    @(negedge Clk);
    @(negedge Clk);
    chk("idle_rvalid", 32'(ia.Rvalid), 32'd0);
    chk("idle_rdata", ia.Rdata, 32'h0);

    // Req held: acceptances 4 apart, Ready low 3 cycles each
    held_req(0, 16, 4, 4, 12);

    // Reset during WAITING abandons the store
    do_xfer(0, 1'b1, 32'h20, 32'h0, rd, er, lat);
    chk("st20_lat", 32'(lat), 32'd3);
    @(negedge Clk);
    @(negedge Clk);
    set_req(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
    @(posedge Clk);
    #1;
    drop_req(0);
    chk("abort_waiting_ready", 32'(ia.Ready), 32'd0);
    #1;
    Reset = 1'b0;
    #1;
    chk("abort_rst_ready", 32'(ia.Ready), 32'd1);
    chk("abort_rst_rvalid", 32'(ia.Rvalid), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (ia.Rvalid) rv_seen++;
    end
    chk("abort_no_rvalid", 32'(rv_seen), 32'd0);
    do_xfer(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("ld20_lat", 32'(lat), 32'd3);
    chk("ld20_rdata", rd, 32'h0);

    // Misaligned load
    do_xfer(0, 1'b0, 32'h13, 32'h0, rd, er, lat);
    chk("ld13_lat", 32'(lat), 32'd3);
`ifdef DMEM_ALIGN_CHK_EN
    chk("ld13_rdata", rd, 32'h0);
    chk("ld13_err", 32'(er), 32'd1);
`else
    chk("ld13_rdata", rd, 32'hDEADBEEF);
    chk("ld13_err", 32'(er), 32'd0);
`endif

    // WAIT=0 instance
    do_xfer(1, 1'b1, 32'h10, 32'hA5A5A5A5, rd, er, lat);
    chk("w0_st_lat", 32'(lat), 32'd1);
    do_xfer(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("w0_ld_lat", 32'(lat), 32'd1);
    chk("w0_ld_rdata", rd, 32'hA5A5A5A5);
    chk("w0_ld_err", 32'(er), 32'd0);
    held_req(1, 8, 2, 4, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
